// File: rtl/alu_ctrl_issue_if.sv
// ID-to-EX ALU control bundle: op request from ID, registered control/valid/busy back toward EX and ID.
// master = alu_ctrl_issue (drives control outputs); slave = the ID/EX side that drives requests.
interface alu_ctrl_issue_if;
  logic       valid_i;
  logic [1:0] ALUOp_i;
  logic [5:0] funct_i;
  logic       stall_i;
  logic       flush_i;
  logic [2:0] ALUCtrl_o;
  logic       valid_o;
  logic       busy_o;
  logic       illegal_o;

  modport master (
    input  valid_i, ALUOp_i, funct_i, stall_i, flush_i,
    output ALUCtrl_o, valid_o, busy_o, illegal_o
  );

  modport slave (
    output valid_i, ALUOp_i, funct_i, stall_i, flush_i,
    input  ALUCtrl_o, valid_o, busy_o, illegal_o
  );
endinterface

// File: rtl/alu_ctrl_issue.sv
// Decodes ALUOp/funct into registered ALUCtrl with valid; 1-cycle latency, MUL_CYCLES for MUL.
// busy_o holds ID while a MUL is in flight; stall_i freezes everything, flush_i clears to idle.
module alu_ctrl_issue #(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  alu_ctrl_issue_if.master bus
);

  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_MUL = 3'b100;
  localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 1);
  localparam bit         MUL_MULTI = (MUL_CYCLES > 1);

  typedef enum logic [1:0] {IDLE, ISSUE, MUL} state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [2:0] ctrl_q;
  logic       valid_q;
  logic       busy_q;
  logic       illegal_q;

  logic [2:0] dec_ctrl;
  logic       dec_ill;
  logic       dec_mul;

  always_comb begin
    dec_ctrl = CTRL_ADD;
    dec_ill  = 1'b0;
    dec_mul  = 1'b0;
    case (bus.ALUOp_i)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: dec_ctrl = CTRL_SUB;
      2'b11: dec_ctrl = CTRL_OR;
      default: begin
        case (bus.funct_i)
          6'b100000: dec_ctrl = CTRL_ADD;
          6'b100010: dec_ctrl = CTRL_SUB;
          6'b100100: dec_ctrl = CTRL_AND;
          6'b100101: dec_ctrl = CTRL_OR;
          6'b011000: begin
            dec_ctrl = CTRL_MUL;
            dec_mul  = 1'b1;
          end
          default:   dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  // Reset and flush share the same clean idle state; stall holds every register.
  always_ff @(posedge clk_i) begin
    if (!rst_i || bus.flush_i) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      ctrl_q    <= CTRL_ADD;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (!bus.stall_i) begin
      case (state_q)
        MUL: begin
          if (cnt_q > 4'd1) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            cnt_q   <= 4'd0;
            state_q <= ISSUE;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          // busy_q is low outside MUL, so valid_i alone means accept here.
          if (bus.valid_i) begin
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_ill;
            if (dec_mul && MUL_MULTI) begin
              state_q <= MUL;
              cnt_q   <= MUL_LOAD;
              busy_q  <= 1'b1;
              valid_q <= 1'b0;
            end else begin
              state_q <= ISSUE;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.ALUCtrl_o = ctrl_q;
  assign bus.valid_o   = valid_q;
  assign bus.busy_o    = busy_q;
  assign bus.illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Table-driven decode vectors plus hand-written MUL/stall/flush/reset sequences with a result scoreboard.
module tb_alu_ctrl_issue;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  alu_ctrl_issue_if ifc();

  alu_ctrl_issue #(.MUL_CYCLES(3)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (ifc.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ctrl;
    logic       ill;
  } exp_t;

  typedef struct {
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [2:0] ctrl;
    logic       ill;
    string      name;
  } vec_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn);
    ifc.valid_i = v;
    ifc.ALUOp_i = op;
    ifc.funct_i = fn;
  endtask

  task automatic chk_out(input string name, input logic v, input logic b, input logic [2:0] c);
    @(negedge clk);
    check({name, "_valid"}, {7'd0, ifc.valid_o}, {7'd0, v});
    check({name, "_busy"},  {7'd0, ifc.busy_o},  {7'd0, b});
    check({name, "_ctrl"},  {5'd0, ifc.ALUCtrl_o}, {5'd0, c});
  endtask

  // Scoreboard: a completed op is consumed by EX on any unstalled cycle with valid_o high.
  always @(negedge clk) begin
    if (ifc.valid_o === 1'b1 && ifc.stall_i === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 8'd1, 8'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_ctrl",    {5'd0, ifc.ALUCtrl_o}, {5'd0, e.ctrl});
        check("sb_illegal", {7'd0, ifc.illegal_o}, {7'd0, e.ill});
      end
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check({name, "_drained"}, 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'b10, 6'b100010, 3'b110, 1'b0, "sub"};
    vecs[1] = '{2'b10, 6'b100100, 3'b000, 1'b0, "and"};
    vecs[2] = '{2'b10, 6'b100101, 3'b001, 1'b0, "or"};
    vecs[3] = '{2'b11, 6'b000000, 3'b001, 1'b0, "ori"};
    vecs[4] = '{2'b00, 6'b111111, 3'b010, 1'b0, "lw"};
    vecs[5] = '{2'b01, 6'b011000, 3'b110, 1'b0, "beq"};
    vecs[6] = '{2'b10, 6'b100000, 3'b010, 1'b0, "add"};
    vecs[7] = '{2'b10, 6'b101010, 3'b010, 1'b1, "slt_illegal"};

    rst_n       = 1'b0;
    ifc.stall_i = 1'b0;
    ifc.flush_i = 1'b0;
    drive(1'b1, 2'b10, 6'b100000);

    // Reset held two cycles with valid_i asserted
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      chk_out("reset", 1'b0, 1'b0, 3'b010);
      check("reset_illegal", {7'd0, ifc.illegal_o}, 8'd0);
    end
    step();
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 6'd0);
    step();

    // Back-to-back decode vectors
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].aluop, vecs[i].funct);
      exp_q.push_back('{vecs[i].ctrl, vecs[i].ill});
      if (i > 0) begin
        @(negedge clk);
        check({"b2b_valid_", vecs[i].name}, {7'd0, ifc.valid_o}, 8'd1);
      end
      step();
    end
    drive(1'b0, 2'b00, 6'd0);
    @(negedge clk);
    check("illegal_with_valid", {6'd0, ifc.valid_o, ifc.illegal_o}, 8'd3);
    wait_drain("table");
    step();

    // MUL latency, add held on valid_i while busy
    drive(1'b1, 2'b10, 6'b011000);
    exp_q.push_back('{3'b100, 1'b0});
    step();
    drive(1'b1, 2'b00, 6'd0);
    exp_q.push_back('{3'b010, 1'b0});
    chk_out("mul_n1", 1'b0, 1'b1, 3'b100);
    step();
    chk_out("mul_n2", 1'b0, 1'b1, 3'b100);
    step();
    chk_out("mul_n3", 1'b1, 1'b0, 3'b100);
    step();
    drive(1'b0, 2'b00, 6'd0);
    chk_out("mul_n4_add", 1'b1, 1'b0, 3'b010);
    wait_drain("mul");
    step();

    // Two stalled cycles mid-MUL delay completion by exactly two
    drive(1'b1, 2'b10, 6'b011000);
    exp_q.push_back('{3'b100, 1'b0});
    step();
    drive(1'b0, 2'b00, 6'd0);
    chk_out("stl_n1", 1'b0, 1'b1, 3'b100);
    step();
    ifc.stall_i = 1'b1;
    chk_out("stl_n2", 1'b0, 1'b1, 3'b100);
    step();
    chk_out("stl_n3", 1'b0, 1'b1, 3'b100);
    step();
    ifc.stall_i = 1'b0;
    chk_out("stl_n4", 1'b0, 1'b1, 3'b100);
    step();
    chk_out("stl_n5", 1'b1, 1'b0, 3'b100);
    step();

    // Completed op held across a stall
    drive(1'b1, 2'b01, 6'd0);
    exp_q.push_back('{3'b110, 1'b0});
    step();
    drive(1'b0, 2'b00, 6'd0);
    ifc.stall_i = 1'b1;
    chk_out("hold1", 1'b1, 1'b0, 3'b110);
    step();
    chk_out("hold2", 1'b1, 1'b0, 3'b110);
    step();
    ifc.stall_i = 1'b0;
    chk_out("hold3", 1'b1, 1'b0, 3'b110);
    step();
    chk_out("hold_done", 1'b0, 1'b0, 3'b110);
    wait_drain("stall");
    step();

    // Flush in N+1 of a MUL drops both the MUL and the incoming op
    drive(1'b1, 2'b10, 6'b011000);
    step();
    drive(1'b1, 2'b00, 6'd0);
    ifc.flush_i = 1'b1;
    chk_out("fl_n1", 1'b0, 1'b1, 3'b100);
    step();
    ifc.flush_i = 1'b0;
    drive(1'b1, 2'b11, 6'd0);
    exp_q.push_back('{3'b001, 1'b0});
    chk_out("fl_n2", 1'b0, 1'b0, 3'b010);
    check("fl_n2_illegal", {7'd0, ifc.illegal_o}, 8'd0);
    step();
    drive(1'b0, 2'b00, 6'd0);
    chk_out("fl_next", 1'b1, 1'b0, 3'b001);
    wait_drain("flush");
    step();

    // Reset at N+1 of a MUL abandons it
    drive(1'b1, 2'b10, 6'b011000);
    step();
    drive(1'b0, 2'b00, 6'd0);
    rst_n = 1'b0;
    chk_out("rst_mul_n1", 1'b0, 1'b1, 3'b100);
    step();
    rst_n = 1'b1;
    chk_out("rst_mul_n2", 1'b0, 1'b0, 3'b010);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      check("rst_mul_no_valid", {7'd0, ifc.valid_o}, 8'd0);
    end
    check("final_queue_empty", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
